// File: rtl/arc4_sched.sv
`timescale 1ns/1ps
// ARC4 phase scheduler: runs the init, KSA and PRGA engines in order and muxes S-memory to the active one.
// Optional watchdog (per-phase cycle limit, sticky err) is enabled by defining ARC4_SCHED_WDOG_EN.
module arc4_sched #(
    parameter logic [15:0] WDOG_LIMIT = 16'd2048
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       rdy,
    output logic       done,
    output logic       err,
    output logic [1:0] phase,
    output logic       init_en,
    output logic       ksa_en,
    output logic       prga_en,
    input  logic       init_rdy,
    input  logic       ksa_rdy,
    input  logic       prga_rdy,
    input  logic [7:0] init_addr,
    input  logic [7:0] ksa_addr,
    input  logic [7:0] prga_addr,
    input  logic [7:0] init_wrdata,
    input  logic [7:0] ksa_wrdata,
    input  logic [7:0] prga_wrdata,
    input  logic       init_wren,
    input  logic       ksa_wren,
    input  logic       prga_wren,
    output logic [7:0] s_addr,
    output logic [7:0] s_wrdata,
    output logic       s_wren
);

    typedef enum logic [2:0] {
        IDLE,
        START_INIT,
        WAIT_INIT,
        START_KSA,
        WAIT_KSA,
        START_PRGA,
        WAIT_PRGA
    } state_t;

    state_t state_q, state_d;
    logic   busy_q, busy_d;
    logic   timeout;
    logic   fin;

    // busy_q records that the engine has dropped rdy since its start pulse;
    // only a later rdy=1 counts as completion.
    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        init_en = 1'b0;
        ksa_en  = 1'b0;
        prga_en = 1'b0;
        fin     = 1'b0;
        case (state_q)
            IDLE: if (en) state_d = START_INIT;
            START_INIT: if (init_rdy) begin
                init_en = 1'b1;
                state_d = WAIT_INIT;
            end
            WAIT_INIT: if (busy_q && init_rdy) state_d = START_KSA;
                       else busy_d = busy_q | ~init_rdy;
            START_KSA: if (ksa_rdy) begin
                ksa_en  = 1'b1;
                state_d = WAIT_KSA;
            end
            WAIT_KSA: if (busy_q && ksa_rdy) state_d = START_PRGA;
                      else busy_d = busy_q | ~ksa_rdy;
            START_PRGA: if (prga_rdy) begin
                prga_en = 1'b1;
                state_d = WAIT_PRGA;
            end
            WAIT_PRGA: if (busy_q && prga_rdy) begin
                state_d = IDLE;
                fin     = 1'b1;
            end else begin
                busy_d = busy_q | ~prga_rdy;
            end
            default: state_d = IDLE;
        endcase
        if (timeout || rst) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            init_en = 1'b0;
            ksa_en  = 1'b0;
            prga_en = 1'b0;
            fin     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

`ifdef ARC4_SCHED_WDOG_EN
    logic [15:0] wdog_q, wdog_d;
    logic        err_q, err_d;

    // The counter restarts on every START entry, so each phase gets its own budget.
    always_comb begin
        timeout = (state_q != IDLE) && ((wdog_q + 16'd1) == WDOG_LIMIT);
        if ((state_d != state_q) && (state_d inside {START_INIT, START_KSA, START_PRGA}))
            wdog_d = 16'd0;
        else if (state_q != IDLE)
            wdog_d = wdog_q + 16'd1;
        else
            wdog_d = 16'd0;
        err_d = err_q;
        if ((state_q == IDLE) && en) err_d = 1'b0;
        if (timeout) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= 16'd0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    assign done = fin;

    always_comb begin
        rdy      = (state_q == IDLE);
        phase    = 2'd0;
        s_addr   = 8'd0;
        s_wrdata = 8'd0;
        s_wren   = 1'b0;
        case (state_q)
            START_INIT, WAIT_INIT: phase = 2'd1;
            START_KSA,  WAIT_KSA:  phase = 2'd2;
            START_PRGA, WAIT_PRGA: phase = 2'd3;
            default:               phase = 2'd0;
        endcase
        // Only the phase owner reaches S-memory; everything else is dropped.
        case (phase)
            2'd1: begin
                s_addr = init_addr; s_wrdata = init_wrdata; s_wren = init_wren;
            end
            2'd2: begin
                s_addr = ksa_addr; s_wrdata = ksa_wrdata; s_wren = ksa_wren;
            end
            2'd3: begin
                s_addr = prga_addr; s_wrdata = prga_wrdata; s_wren = prga_wren;
            end
            default: begin
                s_addr = 8'd0; s_wrdata = 8'd0; s_wren = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_arc4_sched.sv
`timescale 1ns/1ps
// Bench for arc4_sched: stub engines plus a cycle-accurate phase timeline computed from run parameters.
// Define ARC4_SCHED_WDOG_EN to also exercise the watchdog with a 16-cycle limit.
module tb_arc4_sched;

`ifdef ARC4_SCHED_WDOG_EN
    localparam logic [15:0] WDOG = 16'd16;
    localparam int NMAX = 10, DMAX = 3, RST_AT = 5;
`else
    localparam logic [15:0] WDOG = 16'd2048;
    localparam int NMAX = 800, DMAX = 6, RST_AT = 100;
`endif

    logic       clk, rst, en;
    logic       rdy, done, err;
    logic [1:0] phase;
    logic       init_en, ksa_en, prga_en;
    logic       init_rdy, ksa_rdy, prga_rdy;
    logic [7:0] init_addr, ksa_addr, prga_addr;
    logic [7:0] init_wrdata, ksa_wrdata, prga_wrdata;
    logic       init_wren, ksa_wren, prga_wren;
    logic [7:0] s_addr, s_wrdata;
    logic       s_wren;

    arc4_sched #(.WDOG_LIMIT(WDOG)) dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy), .done(done), .err(err), .phase(phase),
        .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
        .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
        .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
        .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata), .prga_wrdata(prga_wrdata),
        .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    // Stub engines: rdy drops the cycle after en and stays low for N cycles.
    // dk/dp hold ksa/prga rdy low for that many cycles of their START phase.
    int ni = 1, nk = 1, np = 1, dk = 0, dp = 0;
    bit prga_stuck = 0, force_wren = 0, pin_ksa = 0;
    int i_cnt = 0, k_cnt = 0, p_cnt = 0, k_dly = 0, p_dly = 0;

    assign init_rdy = (i_cnt == 0);
    assign ksa_rdy  = (k_cnt == 0) && (k_dly == 0);
    assign prga_rdy = (p_cnt == 0) && (p_dly == 0) && !prga_stuck;

    always @(posedge clk) begin
        if (rst) begin
            i_cnt <= 0; k_cnt <= 0; p_cnt <= 0; k_dly <= 0; p_dly <= 0;
        end else begin
            if (init_en) i_cnt <= ni; else if (i_cnt != 0) i_cnt <= i_cnt - 1;
            if (ksa_en)  k_cnt <= nk; else if (k_cnt != 0) k_cnt <= k_cnt - 1;
            if (prga_en) p_cnt <= np; else if (p_cnt != 0) p_cnt <= p_cnt - 1;
            if (i_cnt == 1) k_dly <= dk + 1; else if (k_dly != 0) k_dly <= k_dly - 1;
            if (k_cnt == 1) p_dly <= dp + 1; else if (p_dly != 0) p_dly <= p_dly - 1;
        end
    end

    // Reference timeline: phase 1 covers t1 cycles from k=1, then t2 of phase 2, t3 of phase 3.
    int t1, t2, t3, tot;
    bit rec = 0;
    int k_mon;
    int ph_bad, rdy_bad, mux_bad, multi_bad;
    int ie_n, ke_n, pe_n, dn_n, ie_at, ke_at, pe_at, dn_at, err_at;

    function automatic int exp_phase(input int k);
        if (k >= 1 && k <= t1) return 1;
        if (k > t1 && k <= t1 + t2) return 2;
        if (k > t1 + t2 && k <= t1 + t2 + t3) return 3;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic sample();
        int ep;
        logic [7:0] ea, ed;
        logic ew;
        ep = exp_phase(k_mon);
        ea = 8'd0; ed = 8'd0; ew = 1'b0;
        case (ep)
            1: begin ea = init_addr; ed = init_wrdata; ew = init_wren; end
            2: begin ea = ksa_addr;  ed = ksa_wrdata;  ew = ksa_wren;  end
            3: begin ea = prga_addr; ed = prga_wrdata; ew = prga_wren; end
            default: ;
        endcase
        if ({30'd0, phase} !== ep[31:0]) ph_bad++;
        if (rdy !== (ep == 0)) rdy_bad++;
        if ({s_addr, s_wrdata, s_wren} !== {ea, ed, ew}) mux_bad++;
        if (int'(init_en) + int'(ksa_en) + int'(prga_en) > 1) multi_bad++;
        if (init_en === 1'b1) begin ie_n++; ie_at = k_mon; end
        if (ksa_en === 1'b1)  begin ke_n++; ke_at = k_mon; end
        if (prga_en === 1'b1) begin pe_n++; pe_at = k_mon; end
        if (done === 1'b1)    begin dn_n++; dn_at = k_mon; end
        if (err === 1'b1 && err_at < 0) err_at = k_mon;
    endtask

    task automatic step(input logic en_v, input logic rst_v);
        @(posedge clk);
        #1;
        en = en_v;
        rst = rst_v;
        init_addr = 8'($urandom); ksa_addr = 8'($urandom); prga_addr = 8'($urandom);
        init_wrdata = 8'($urandom); ksa_wrdata = 8'($urandom); prga_wrdata = 8'($urandom);
        init_wren = 1'($urandom); ksa_wren = 1'($urandom); prga_wren = 1'($urandom);
        if (force_wren) begin init_wren = 1'b1; ksa_wren = 1'b1; prga_wren = 1'b1; end
        if (pin_ksa) begin ksa_addr = 8'h2A; ksa_wren = 1'b1; init_wren = 1'b1; end
        #4;
        if (rec) sample();
    endtask

    task automatic begin_model(input int a, input int b, input int c, input int d1, input int d2,
                               input bit abort_v);
        ni = a; nk = b; np = c; dk = d1; dp = d2;
        t1 = ni + 2;
        t2 = dk + nk + 2;
        t3 = abort_v ? int'(WDOG) : dp + np + 2;
        tot = t1 + t2 + t3;
        ph_bad = 0; rdy_bad = 0; mux_bad = 0; multi_bad = 0;
        ie_n = 0; ke_n = 0; pe_n = 0; dn_n = 0;
        ie_at = -1; ke_at = -1; pe_at = -1; dn_at = -1; err_at = -1;
        rec = 1;
    endtask

    task automatic do_run(input string tag, input int a, input int b, input int c,
                          input int d1, input int d2, input bit extra, input bit abort_v);
        begin_model(a, b, c, d1, d2, abort_v);
        for (int k = 0; k <= tot + 3; k++) begin
            logic e;
            if (k == 0) e = 1'b1;
            else if (k == tot) e = extra;
            else if (k < tot && extra) e = 1'($urandom_range(0, 1));
            else e = 1'b0;
            k_mon = k;
            step(e, 1'b0);
        end
        rec = 0;
        chk($sformatf("%s init_en count", tag), ie_n, 1);
        chk($sformatf("%s init_en cycle", tag), ie_at, 1);
        chk($sformatf("%s ksa_en count", tag), ke_n, 1);
        chk($sformatf("%s ksa_en cycle", tag), ke_at, t1 + 1 + dk);
        chk($sformatf("%s prga_en count", tag), pe_n, abort_v ? 0 : 1);
        chk($sformatf("%s prga_en cycle", tag), pe_at, abort_v ? -1 : t1 + t2 + 1 + dp);
        chk($sformatf("%s done count", tag), dn_n, abort_v ? 0 : 1);
        chk($sformatf("%s done cycle", tag), dn_at, abort_v ? -1 : tot);
        chk($sformatf("%s phase timeline errors", tag), ph_bad, 0);
        chk($sformatf("%s rdy timeline errors", tag), rdy_bad, 0);
        chk($sformatf("%s s-mux errors", tag), mux_bad, 0);
        chk($sformatf("%s multiple en cycles", tag), multi_bad, 0);
        chk($sformatf("%s err first cycle", tag), err_at, abort_v ? t1 + t2 + 1 + int'(WDOG) : -1);
        chk($sformatf("%s err at end", tag), {31'd0, err}, {31'd0, abort_v});
    endtask

    function automatic int clamp(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

    initial begin
        en = 1'b0;
        rst = 1'b1;
        repeat (3) step(1'b0, 1'b1);

        force_wren = 1;
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        chk("reset rdy", {31'd0, rdy}, 1);
        chk("reset phase", {30'd0, phase}, 0);
        chk("reset done", {31'd0, done}, 0);
        chk("reset err", {31'd0, err}, 0);
        chk("reset en pulses", {29'd0, init_en, ksa_en, prga_en}, 0);
        chk("reset s_addr", {24'd0, s_addr}, 0);
        chk("reset s_wrdata", {24'd0, s_wrdata}, 0);
        chk("reset s_wren", {31'd0, s_wren}, 0);
        force_wren = 0;

        do_run("normal", clamp(256, NMAX), clamp(768, NMAX), clamp(53, NMAX), 0, 0, 0, 0);

        pin_ksa = 1;
        do_run("ack_delay", clamp(20, NMAX), clamp(30, NMAX), clamp(40, NMAX),
               clamp(5, DMAX), 0, 0, 0);
        pin_ksa = 0;

        for (int r = 0; r < 3; r++) begin
            do_run($sformatf("rand%0d", r),
                   $urandom_range(1, clamp(300, NMAX)), $urandom_range(1, clamp(300, NMAX)),
                   $urandom_range(1, clamp(300, NMAX)),
                   $urandom_range(0, DMAX), $urandom_range(0, DMAX), 1, 0);
        end

        // Reset in cycle RST_AT of the KSA phase.
        begin_model(clamp(5, NMAX), clamp(768, NMAX), 4, 0, 0, 0);
        for (int k = 0; k < t1 + RST_AT; k++) begin
            k_mon = k;
            step(k == 0, 1'b0);
        end
        k_mon = t1 + RST_AT;
        step(1'b0, 1'b1);
        rec = 0;
        chk("midrst pre-reset phase errors", ph_bad, 0);
        chk("midrst ksa_en count", ke_n, 1);
        step(1'b0, 1'b0);
        chk("midrst phase", {30'd0, phase}, 0);
        chk("midrst rdy", {31'd0, rdy}, 1);
        chk("midrst en pulses", {29'd0, init_en, ksa_en, prga_en}, 0);
        chk("midrst done", {31'd0, done}, 0);
        chk("midrst s_wren", {31'd0, s_wren}, 0);
        chk("midrst s_addr", {24'd0, s_addr}, 0);

        do_run("restart", clamp(7, NMAX), clamp(9, NMAX), clamp(11, NMAX), 0, 0, 1, 0);

`ifdef ARC4_SCHED_WDOG_EN
        prga_stuck = 1;
        do_run("wdog", 3, 3, 3, 0, 0, 0, 1);
        prga_stuck = 0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("wdog err cleared by en", {31'd0, err}, 0);
        chk("wdog restart phase", {30'd0, phase}, 1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
